// File: rtl/grf_write_arbiter.sv
// Register-file write-port arbiter: same-cycle primary write-back merged with a
// FIFO-queued multi-cycle result stream, plus a pending-write query for the decoder.
module grf_write_arbiter #(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pri_valid,
    input  logic [31:0] pri_pc,
    input  logic [4:0]  pri_addr,
    input  logic [31:0] pri_data,
    output logic        pri_stall,
    input  logic        sec_valid,
    output logic        sec_ready,
    input  logic [31:0] sec_pc,
    input  logic [4:0]  sec_addr,
    input  logic [31:0] sec_data,
    input  logic [4:0]  query_addr,
    output logic        query_busy,
    output logic [31:0] wr_pc,
    output logic [4:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic        wr_en
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int WW = $clog2(MAX_WAIT + 1);

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_req_t;

    wr_req_t        mem [DEPTH];
    logic [PW-1:0]  head, tail;
    logic [CW-1:0]  count;
    logic [WW-1:0]  wait_cnt;
    wr_req_t        head_e, pri_e, sec_e, sel;
    logic           empty, full, push, pop, force_slot;
    logic [DEPTH-1:0] hit;

    assign pri_e = '{pc: pri_pc, addr: pri_addr, data: pri_data};
    assign sec_e = '{pc: sec_pc, addr: sec_addr, data: sec_data};

    always_comb begin
        empty      = (count == '0);
        full       = (count == CW'(DEPTH));
        head_e     = mem[head];
        force_slot = !empty && (wait_cnt == WW'(MAX_WAIT));
        // No push-through: readiness depends on registered count only.
        sec_ready  = !reset && !full;
        push       = sec_valid && sec_ready;
    end

    always_comb begin
        sel       = '0;
        wr_en     = 1'b0;
        pop       = 1'b0;
        pri_stall = 1'b0;
        if (!reset) begin
            if (force_slot) begin
                sel       = head_e;
                wr_en     = 1'b1;
                pop       = 1'b1;
                pri_stall = pri_valid;
            end else if (pri_valid) begin
                sel   = pri_e;
                wr_en = 1'b1;
            end else if (!empty) begin
                sel   = head_e;
                wr_en = 1'b1;
                pop   = 1'b1;
            end
        end
    end

    assign wr_pc   = sel.pc;
    assign wr_addr = sel.addr;
    assign wr_data = sel.data;

    always_ff @(posedge clk) begin
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            wait_cnt <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
            // A non-empty head that was not popped lost to primary this cycle.
            if (pop || empty)
                wait_cnt <= '0;
            else if (wait_cnt != WW'(MAX_WAIT))
                wait_cnt <= wait_cnt + WW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[tail] <= sec_e;
    end

    // Entry i is live when its distance from head is below count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_match
        logic [PW-1:0] off;
        assign off    = PW'(i) - head;
        assign hit[i] = (CW'(off) < count) && (mem[i].addr == query_addr);
    end

    assign query_busy = !reset && (query_addr != 5'd0) && (|hit);

endmodule

// File: tb/tb_grf_write_arbiter.sv
// Directed bench: expected register-file writes are queued as stimulus is driven
// and matched in order against every wr_en pulse.
module tb_grf_write_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        pri_valid, sec_valid, sec_ready, pri_stall, query_busy, wr_en;
    logic [31:0] pri_pc, pri_data, sec_pc, sec_data, wr_pc, wr_data;
    logic [4:0]  pri_addr, sec_addr, query_addr, wr_addr;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_chk  = 0;
    int  n_fail = 0;

    grf_write_arbiter #(.DEPTH(4), .MAX_WAIT(3)) dut (
        .clk(clk), .reset(reset),
        .pri_valid(pri_valid), .pri_pc(pri_pc), .pri_addr(pri_addr), .pri_data(pri_data),
        .pri_stall(pri_stall),
        .sec_valid(sec_valid), .sec_ready(sec_ready), .sec_pc(sec_pc), .sec_addr(sec_addr),
        .sec_data(sec_data),
        .query_addr(query_addr), .query_busy(query_busy),
        .wr_pc(wr_pc), .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_pri(input logic v, input logic [31:0] pc, input logic [4:0] a,
                             input logic [31:0] d);
        pri_valid = v; pri_pc = pc; pri_addr = a; pri_data = d;
    endtask

    task automatic drive_sec(input logic v, input logic [31:0] pc, input logic [4:0] a,
                             input logic [31:0] d);
        sec_valid = v; sec_pc = pc; sec_addr = a; sec_data = d;
    endtask

    task automatic expw(input logic [31:0] pc, input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.pc = pc; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Every write at the port must match the next expected write, in order.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("wr_unexpected", 32'(wr_en), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_pc",   wr_pc,          mon_e.pc);
                chk("wr_addr", 32'(wr_addr),   32'(mon_e.addr));
                chk("wr_data", wr_data,        mon_e.data);
            end
        end
    end

    initial begin
        // Reset with live requests on both sides: nothing may leak through.
        reset = 1'b1;
        drive_pri(1'b1, 32'h1000, 5'd3, 32'h33);
        drive_sec(1'b1, 32'h7000, 5'd7, 32'h77);
        query_addr = 5'd7;
        smp();
        chk("rst_wr_en",      32'(wr_en),      32'd0);
        chk("rst_pri_stall",  32'(pri_stall),  32'd0);
        chk("rst_sec_ready",  32'(sec_ready),  32'd0);
        chk("rst_query_busy", 32'(query_busy), 32'd0);
        step();
        reset = 1'b0;
        drive_pri(1'b0, 32'h0, 5'd0, 32'h0);
        drive_sec(1'b0, 32'h0, 5'd0, 32'h0);
        smp();
        chk("idle_wr_en",      32'(wr_en),      32'd0);
        chk("idle_sec_ready",  32'(sec_ready),  32'd1);
        chk("idle_pri_stall",  32'(pri_stall),  32'd0);
        chk("idle_query_busy", 32'(query_busy), 32'd0);

        // Primary only: written in the same cycle.
        step();
        drive_pri(1'b1, 32'h3000, 5'd8, 32'h1234);
        expw(32'h3000, 5'd8, 32'h1234);
        smp();
        chk("pri_wr_en",  32'(wr_en),     32'd1);
        chk("pri_stall0", 32'(pri_stall), 32'd0);

        // Secondary on an idle port: one cycle after accept.
        step();
        drive_pri(1'b0, 32'h0, 5'd0, 32'h0);
        drive_sec(1'b1, 32'h3004, 5'd9, 32'hABCD);
        query_addr = 5'd9;
        expw(32'h3004, 5'd9, 32'hABCD);
        smp();
        chk("sec_accept_wr_en", 32'(wr_en),      32'd0);
        chk("sec_accept_busy",  32'(query_busy), 32'd0);
        step();
        drive_sec(1'b0, 32'h0, 5'd0, 32'h0);
        smp();
        chk("sec_pop_wr_en", 32'(wr_en),      32'd1);
        chk("sec_pop_busy",  32'(query_busy), 32'd1);
        step();
        smp();
        chk("sec_drained_wr_en", 32'(wr_en),      32'd0);
        chk("sec_after_pop_busy", 32'(query_busy), 32'd0);

        // Starvation: three primary wins, then a forced slot.
        step();
        drive_sec(1'b1, 32'h4000, 5'd10, 32'h55);
        drive_pri(1'b1, 32'h5000, 5'd11, 32'h0);
        expw(32'h5000, 5'd11, 32'h0);
        smp();
        step();
        drive_sec(1'b0, 32'h0, 5'd0, 32'h0);
        query_addr = 5'd10;
        for (int k = 1; k <= 3; k++) begin
            drive_pri(1'b1, 32'h5000 + 32'(4 * k), 5'd11, 32'(k));
            expw(32'h5000 + 32'(4 * k), 5'd11, 32'(k));
            smp();
            chk("starve_pri_stall", 32'(pri_stall),  32'd0);
            chk("starve_busy",      32'(query_busy), 32'd1);
            step();
        end
        drive_pri(1'b1, 32'h5010, 5'd11, 32'd4);
        expw(32'h4000, 5'd10, 32'h55);
        expw(32'h5010, 5'd11, 32'd4);
        smp();
        chk("force_pri_stall", 32'(pri_stall), 32'd1);
        step();
        smp();
        chk("resume_pri_stall", 32'(pri_stall), 32'd0);
        step();

        // Full FIFO: four pushes under primary traffic, fifth refused.
        for (int k = 1; k <= 4; k++) begin
            drive_sec(1'b1, 32'h6000 + 32'(k), 5'(k), 32'h100 + 32'(k));
            drive_pri(1'b1, 32'h7000 + 32'(k), 5'd20, 32'(k));
            expw(32'h7000 + 32'(k), 5'd20, 32'(k));
            smp();
            chk("fill_sec_ready", 32'(sec_ready), 32'd1);
            step();
        end
        drive_sec(1'b1, 32'h6005, 5'd5, 32'h105);
        drive_pri(1'b1, 32'h7005, 5'd20, 32'd5);
        expw(32'h6001, 5'd1, 32'h101);
        expw(32'h7005, 5'd20, 32'd5);
        for (int k = 2; k <= 4; k++) expw(32'h6000 + 32'(k), 5'(k), 32'h100 + 32'(k));
        smp();
        chk("full_sec_ready", 32'(sec_ready), 32'd0);
        chk("full_pri_stall", 32'(pri_stall), 32'd1);
        step();
        drive_sec(1'b0, 32'h0, 5'd0, 32'h0);
        smp();
        chk("full_ready_after_pop", 32'(sec_ready), 32'd1);
        step();
        drive_pri(1'b0, 32'h0, 5'd0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            smp();
            chk("drain_wr_en", 32'(wr_en), 32'd1);
            step();
        end
        query_addr = 5'd5;
        smp();
        chk("drain_done_wr_en", 32'(wr_en),      32'd0);
        chk("refused_not_busy", 32'(query_busy), 32'd0);
        step();

        // query_busy with an addr-5 and an addr-0 entry held back by primary.
        drive_sec(1'b1, 32'h8000, 5'd5, 32'h500);
        drive_pri(1'b1, 32'h9000, 5'd21, 32'd0);
        expw(32'h9000, 5'd21, 32'd0);
        smp();
        step();
        drive_sec(1'b1, 32'h8004, 5'd0, 32'h504);
        drive_pri(1'b1, 32'h9004, 5'd21, 32'd1);
        expw(32'h9004, 5'd21, 32'd1);
        query_addr = 5'd5;
        smp();
        chk("query_hit", 32'(query_busy), 32'd1);
        step();
        drive_sec(1'b0, 32'h0, 5'd0, 32'h0);
        drive_pri(1'b1, 32'h9008, 5'd21, 32'd2);
        expw(32'h9008, 5'd21, 32'd2);
        query_addr = 5'd6;
        smp();
        chk("query_miss", 32'(query_busy), 32'd0);
        step();
        drive_pri(1'b1, 32'h900C, 5'd21, 32'd3);
        expw(32'h900C, 5'd21, 32'd3);
        query_addr = 5'd0;
        smp();
        chk("query_zero", 32'(query_busy), 32'd0);
        step();
        drive_pri(1'b1, 32'h9010, 5'd21, 32'd4);
        expw(32'h8000, 5'd5, 32'h500);
        expw(32'h9010, 5'd21, 32'd4);
        query_addr = 5'd5;
        smp();
        chk("query_pop_busy",  32'(query_busy), 32'd1);
        chk("query_pop_stall", 32'(pri_stall),  32'd1);
        step();
        smp();
        chk("query_after_pop", 32'(query_busy), 32'd0);
        step();
        drive_pri(1'b0, 32'h0, 5'd0, 32'h0);
        expw(32'h8004, 5'd0, 32'h504);
        smp();
        chk("zero_entry_wr_en", 32'(wr_en), 32'd1);
        step();

        // Reset mid-operation drops three queued entries.
        for (int k = 0; k < 3; k++) begin
            drive_sec(1'b1, 32'hA000 + 32'(k), 5'(12 + k), 32'hA0 + 32'(k));
            drive_pri(1'b1, 32'hB000 + 32'(k), 5'd22, 32'(k));
            expw(32'hB000 + 32'(k), 5'd22, 32'(k));
            smp();
            step();
        end
        reset = 1'b1;
        drive_sec(1'b0, 32'h0, 5'd0, 32'h0);
        drive_pri(1'b0, 32'h0, 5'd0, 32'h0);
        smp();
        chk("midrst_wr_en", 32'(wr_en), 32'd0);
        step();
        reset = 1'b0;
        query_addr = 5'd12;
        smp();
        chk("postrst_wr_en",     32'(wr_en),      32'd0);
        chk("postrst_sec_ready", 32'(sec_ready),  32'd1);
        chk("postrst_busy",      32'(query_busy), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            smp();
            chk("postrst_idle_wr_en", 32'(wr_en), 32'd0);
        end

        chk("exp_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
